// File: rtl/tcm_dual_mem.sv
// Dual-port TCM: 64-bit fetch port and 32-bit data port sharing one 64-bit RAM array.
// Latency: fetch and data responses one cycle after the request edge (registered).
// Backpressure: none; both accept outputs are tied high and every request is answered.
// Build option: define TCM_ADDR_CHECK_EN to flag accesses outside [BASE_ADDR, BASE_ADDR+MEM_BYTES).

module tcm_dual_mem_ram #(
  parameter int DEPTH = 16384,
  parameter int IW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [IW-1:0] i_idx,
  output logic [63:0]   i_dat,
  input  logic          d_en,
  input  logic [IW-1:0] d_idx,
  input  logic [7:0]    d_we,
  input  logic [63:0]   d_wdat,
  output logic [63:0]   d_dat
);

  logic [63:0] ram [DEPTH];

  // Byte-lane writes; reads below see the pre-write word on a same-cycle collision.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (d_we[b]) ram[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
    end
  end

  // Registered read ports, cleared by reset so outputs start at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_dat <= '0;
      d_dat <= '0;
    end else begin
      if (i_en) i_dat <= ram[i_idx];
      if (d_en) d_dat <= ram[d_idx];
    end
  end

  // Simulation backdoor: one byte at a byte offset (upper address bits wrap).
  task automatic bd_write(input logic [31:0] addr, input logic [7:0] data);
    ram[addr[IW+2:3]][{addr[2:0], 3'b000} +: 8] <= data;
  endtask

endmodule

module tcm_dual_mem #(
  parameter int          MEM_BYTES = 131072,
  parameter logic [31:0] BASE_ADDR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IW    = AW - 3;
  localparam int DEPTH = MEM_BYTES / 8;

  logic          d_req;
  logic          i_win;
  logic          d_win;
  logic [IW-1:0] i_idx;
  logic [IW-1:0] d_idx;
  logic [3:0]    we4;
  logic [7:0]    d_we;
  logic [63:0]   i_dat;
  logic [63:0]   d_dat;
  logic [31:0]   d_sel;
  logic          i_vld_q;
  logic          d_ack_q;
  logic          d_hi_q;
  logic [10:0]   d_tag_q;
  logic          unused_ok;

  // Flush/invalidate on the fetch side and cacheable are accepted but have no effect.
  assign unused_ok = ^{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                       mem_i_pc_i, mem_d_addr_i, BASE_ADDR};

  assign mem_i_accept_o = 1'b1;
  assign mem_d_accept_o = 1'b1;

  // Maintenance operations still count as requests so they get an ack and tag.
  assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i |
                 mem_d_writeback_i | mem_d_flush_i;

  assign i_idx = mem_i_pc_i[AW-1:3];
  assign d_idx = mem_d_addr_i[AW-1:3];

`ifdef TCM_ADDR_CHECK_EN
  assign i_win = (mem_i_pc_i - BASE_ADDR) < 32'(MEM_BYTES);
  assign d_win = (mem_d_addr_i - BASE_ADDR) < 32'(MEM_BYTES);
`else
  assign i_win = 1'b1;
  assign d_win = 1'b1;
`endif

  // Writes are dropped during reset and for out-of-window addresses.
  assign we4  = mem_d_wr_i & {4{d_win & ~rst_i}};
  assign d_we = mem_d_addr_i[2] ? {we4, 4'b0000} : {4'b0000, we4};

  tcm_dual_mem_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk    (clk_i),
    .rst    (rst_i),
    .i_en   (mem_i_rd_i & ~rst_i),
    .i_idx  (i_idx),
    .i_dat  (i_dat),
    .d_en   (d_req & ~rst_i),
    .d_idx  (d_idx),
    .d_we   (d_we),
    .d_wdat ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .d_dat  (d_dat)
  );

  // Response control: valid/ack pulse one cycle after each request, tag and half-select held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_vld_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_hi_q  <= 1'b0;
      d_tag_q <= '0;
    end else begin
      i_vld_q <= mem_i_rd_i;
      d_ack_q <= d_req;
      if (d_req) begin
        d_hi_q  <= mem_d_addr_i[2];
        d_tag_q <= mem_d_req_tag_i;
      end
    end
  end

  assign d_sel            = d_hi_q ? d_dat[63:32] : d_dat[31:0];
  assign mem_i_valid_o    = i_vld_q;
  assign mem_d_ack_o      = d_ack_q;
  assign mem_d_resp_tag_o = d_tag_q;

`ifdef TCM_ADDR_CHECK_EN
  logic i_err_q;
  logic d_err_q;

  // Error flags track the window check of the request being answered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      i_err_q <= mem_i_rd_i & ~i_win;
      d_err_q <= d_req & ~d_win;
    end
  end

  assign mem_i_error_o   = i_err_q;
  assign mem_d_error_o   = d_err_q;
  assign mem_i_inst_o    = i_err_q ? 64'd0 : i_dat;
  assign mem_d_data_rd_o = d_err_q ? 32'd0 : d_sel;
`else
  assign mem_i_error_o   = 1'b0;
  assign mem_d_error_o   = 1'b0;
  assign mem_i_inst_o    = i_dat;
  assign mem_d_data_rd_o = d_sel;
`endif

  // Program-image loader: one byte at byte offset addr mod MEM_BYTES.
  task automatic write(input logic [31:0] addr, input logic [7:0] data);
    u_ram.bd_write(addr, data);
  endtask

endmodule

// File: tb/tb_tcm_dual_mem.sv
// Testbench for tcm_dual_mem: directed steps plus random traffic against a byte-array model.
// Latency: expects responses one cycle after each request.
// Backpressure: none expected; accept outputs checked high.

module tb_tcm_dual_mem;

  localparam int          MEM  = 131072;
  localparam logic [31:0] BASE = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic [31:0] mem_d_data_rd_o;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [MEM];

  always #5 clk = ~clk;

  tcm_dual_mem dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .mem_i_rd_i         (mem_i_rd_i),
    .mem_i_flush_i      (mem_i_flush_i),
    .mem_i_invalidate_i (mem_i_invalidate_i),
    .mem_i_pc_i         (mem_i_pc_i),
    .mem_i_accept_o     (mem_i_accept_o),
    .mem_i_valid_o      (mem_i_valid_o),
    .mem_i_error_o      (mem_i_error_o),
    .mem_i_inst_o       (mem_i_inst_o),
    .mem_d_addr_i       (mem_d_addr_i),
    .mem_d_data_wr_i    (mem_d_data_wr_i),
    .mem_d_rd_i         (mem_d_rd_i),
    .mem_d_wr_i         (mem_d_wr_i),
    .mem_d_cacheable_i  (mem_d_cacheable_i),
    .mem_d_req_tag_i    (mem_d_req_tag_i),
    .mem_d_invalidate_i (mem_d_invalidate_i),
    .mem_d_writeback_i  (mem_d_writeback_i),
    .mem_d_flush_i      (mem_d_flush_i),
    .mem_d_data_rd_o    (mem_d_data_rd_o),
    .mem_d_accept_o     (mem_d_accept_o),
    .mem_d_ack_o        (mem_d_ack_o),
    .mem_d_error_o      (mem_d_error_o),
    .mem_d_resp_tag_o   (mem_d_resp_tag_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: flat byte array, byte offset = address mod MEM.
  function automatic int off(input logic [31:0] a);
    return int'(a & 32'(MEM - 1));
  endfunction

  function automatic logic [63:0] m_rd64(input logic [31:0] a);
    logic [63:0] r;
    int b;
    b = off(a) & ~7;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mb[b + k];
    return r;
  endfunction

  function automatic logic [31:0] m_rd32(input logic [31:0] a);
    logic [31:0] r;
    int b;
    b = off(a) & ~3;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mb[b + k];
    return r;
  endfunction

  task automatic m_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    int b;
    b = off(a) & ~3;
    for (int k = 0; k < 4; k++) if (strb[k]) mb[b + k] = d[8*k +: 8];
  endtask

  task automatic bd(input logic [31:0] a, input logic [7:0] d);
    dut.write(a, d);
    mb[off(a)] = d;
  endtask

  task automatic idle();
    mem_i_rd_i         = 1'b0;
    mem_d_rd_i         = 1'b0;
    mem_d_wr_i         = 4'h0;
    mem_d_invalidate_i = 1'b0;
    mem_d_writeback_i  = 1'b0;
    mem_d_flush_i      = 1'b0;
  endtask

  // One in-window data transaction checked against the model (pre-write data for writes).
  task automatic txn(input string nm, input logic [31:0] a, input logic rd, input logic [3:0] wr,
                     input logic [31:0] wd, input logic [10:0] tag, output logic [31:0] got);
    logic [31:0] exp;
    mem_d_addr_i    = a;
    mem_d_rd_i      = rd;
    mem_d_wr_i      = wr;
    mem_d_data_wr_i = wd;
    mem_d_req_tag_i = tag;
    exp = m_rd32(a);
    m_wr(a, wd, wr);
    @(negedge clk);
    idle();
    got = mem_d_data_rd_o;
    chk({nm, "_ack"}, 64'(mem_d_ack_o), 64'd1);
    chk({nm, "_tag"}, 64'(mem_d_resp_tag_o), 64'(tag));
    chk({nm, "_dat"}, 64'(mem_d_data_rd_o), 64'(exp));
    chk({nm, "_err"}, 64'(mem_d_error_o), 64'd0);
  endtask

  initial begin
    logic [31:0] got, a, pc, wd;
    logic [63:0] exp64;
    logic        f, rd, mt, ack_e, dchk_e;
    logic [3:0]  wr;
    logic [10:0] tg;
    logic [31:0] dexp;

    rst_i = 1'b1;
    mem_i_flush_i = 1'b0; mem_i_invalidate_i = 1'b0; mem_d_cacheable_i = 1'b0;
    mem_i_pc_i = '0; mem_d_addr_i = '0; mem_d_data_wr_i = '0; mem_d_req_tag_i = '0;
    idle();

    // Preload a random region plus the collision word, then the test-plan instruction.
    for (int i = 0; i < 512; i++) bd(BASE + 32'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) bd(BASE + 32'h18000 + 32'(i), 8'($urandom));
    bd(BASE + 0, 8'h13); bd(BASE + 1, 8'h00); bd(BASE + 2, 8'h00); bd(BASE + 3, 8'h00);

    // Requests during reset are dropped; the write must not land.
    mem_i_rd_i = 1'b1; mem_i_pc_i = BASE;
    mem_d_rd_i = 1'b1; mem_d_wr_i = 4'hF; mem_d_addr_i = BASE + 32'h108;
    mem_d_data_wr_i = 32'hCAFEF00D; mem_d_req_tag_i = 11'h3;
    repeat (2) @(negedge clk);
    chk("rst_ivalid", 64'(mem_i_valid_o), 64'd0);
    chk("rst_ierr", 64'(mem_i_error_o), 64'd0);
    chk("rst_inst", mem_i_inst_o, 64'd0);
    chk("rst_ack", 64'(mem_d_ack_o), 64'd0);
    chk("rst_derr", 64'(mem_d_error_o), 64'd0);
    chk("rst_drd", 64'(mem_d_data_rd_o), 64'd0);
    chk("rst_tag", 64'(mem_d_resp_tag_o), 64'd0);
    chk("rst_iacc", 64'(mem_i_accept_o), 64'd1);
    chk("rst_dacc", 64'(mem_d_accept_o), 64'd1);
    rst_i = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_ivalid", 64'(mem_i_valid_o), 64'd0);
    chk("post_rst_ack", 64'(mem_d_ack_o), 64'd0);

    // Fetch of the backdoor-loaded instruction.
    mem_i_rd_i = 1'b1; mem_i_pc_i = BASE;
    @(negedge clk);
    idle();
    chk("fetch0_valid", 64'(mem_i_valid_o), 64'd1);
    chk("fetch0_lo", 64'(mem_i_inst_o[31:0]), 64'h13);
    chk("fetch0_full", mem_i_inst_o, m_rd64(BASE));
    @(negedge clk);
    chk("fetch0_once", 64'(mem_i_valid_o), 64'd0);

    // Full write, readback, neighbour word, and the address written during reset.
    txn("wr104", BASE + 32'h104, 1'b0, 4'hF, 32'hDEADBEEF, 11'h5, got);
    txn("rd104", BASE + 32'h104, 1'b1, 4'h0, 32'h0, 11'h6, got);
    chk("rd104_const", 64'(got), 64'hDEADBEEF);
    txn("rd100", BASE + 32'h100, 1'b1, 4'h0, 32'h0, 11'h7, got);
    txn("rd108", BASE + 32'h108, 1'b1, 4'h0, 32'h0, 11'h8, got);

    // Partial byte-lane write.
    txn("wr10c", BASE + 32'h10C, 1'b0, 4'hF, 32'h11223344, 11'h9, got);
    txn("pwr10c", BASE + 32'h10C, 1'b0, 4'b0010, 32'h0000AB00, 11'hA, got);
    txn("rd10c", BASE + 32'h10C, 1'b1, 4'h0, 32'h0, 11'hB, got);
    chk("rd10c_const", 64'(got), 64'h1122AB44);

    // Back-to-back reads: one ack per cycle, tags in order.
    for (int i = 1; i <= 3; i++) begin
      mem_d_rd_i = 1'b1; mem_d_addr_i = BASE + 32'(8 * i + 4); mem_d_req_tag_i = 11'(i);
      dexp = m_rd32(mem_d_addr_i);
      @(negedge clk);
      chk("b2b_ack", 64'(mem_d_ack_o), 64'd1);
      chk("b2b_tag", 64'(mem_d_resp_tag_o), 64'(i));
      chk("b2b_dat", 64'(mem_d_data_rd_o), 64'(dexp));
    end
    idle();
    @(negedge clk);
    chk("b2b_ack_end", 64'(mem_d_ack_o), 64'd0);

    // Maintenance-only requests: ack and tag, no data change.
    for (int k = 0; k < 3; k++) begin
      mem_d_addr_i = BASE + 32'h104; mem_d_data_wr_i = 32'h0; mem_d_req_tag_i = 11'h7FF - 11'(k);
      mem_d_invalidate_i = (k == 0); mem_d_writeback_i = (k == 1); mem_d_flush_i = (k == 2);
      @(negedge clk);
      idle();
      chk("maint_ack", 64'(mem_d_ack_o), 64'd1);
      chk("maint_tag", 64'(mem_d_resp_tag_o), 64'(11'h7FF - 11'(k)));
    end
    txn("maint_rd", BASE + 32'h104, 1'b1, 4'h0, 32'h0, 11'h1, got);
    chk("maint_keep", 64'(got), 64'hDEADBEEF);

    // Same-cycle write and fetch to one word: old data now, new data next fetch.
    a = BASE + 32'h18000;
    wd = $urandom;
    exp64 = m_rd64(a);
    mem_i_rd_i = 1'b1; mem_i_pc_i = a;
    mem_d_wr_i = 4'hF; mem_d_addr_i = a + 4; mem_d_data_wr_i = wd; mem_d_req_tag_i = 11'h42;
    m_wr(a + 4, wd, 4'hF);
    @(negedge clk);
    mem_d_wr_i = 4'h0;
    chk("coll_old", mem_i_inst_o, exp64);
    chk("coll_ack", 64'(mem_d_ack_o), 64'd1);
    @(negedge clk);
    idle();
    chk("coll_new_valid", 64'(mem_i_valid_o), 64'd1);
    chk("coll_new", mem_i_inst_o, m_rd64(a));
    chk("coll_new_hi", 64'(mem_i_inst_o[63:32]), 64'(wd));

    // Addresses outside the window: error with the check, wrap without it.
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h00018000;
    mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h90000000; mem_d_req_tag_i = 11'h55;
    @(negedge clk);
    idle();
    chk("oow_ivalid", 64'(mem_i_valid_o), 64'd1);
    chk("oow_ack", 64'(mem_d_ack_o), 64'd1);
    chk("oow_tag", 64'(mem_d_resp_tag_o), 64'h55);
`ifdef TCM_ADDR_CHECK_EN
    chk("oow_ierr", 64'(mem_i_error_o), 64'd1);
    chk("oow_inst", mem_i_inst_o, 64'd0);
    chk("oow_derr", 64'(mem_d_error_o), 64'd1);
    chk("oow_drd", 64'(mem_d_data_rd_o), 64'd0);
`else
    chk("wrap_ierr", 64'(mem_i_error_o), 64'd0);
    chk("wrap_inst", mem_i_inst_o, m_rd64(32'h00018000));
    chk("wrap_derr", 64'(mem_d_error_o), 64'd0);
    chk("wrap_drd", 64'(mem_d_data_rd_o), 64'(m_rd32(32'h90000000)));
`endif
    mem_d_wr_i = 4'hF; mem_d_addr_i = 32'h10000104; mem_d_data_wr_i = 32'h5A5A1234;
`ifndef TCM_ADDR_CHECK_EN
    m_wr(32'h10000104, 32'h5A5A1234, 4'hF);
`endif
    @(negedge clk);
    idle();
    txn("oow_wr_rd", BASE + 32'h104, 1'b1, 4'h0, 32'h0, 11'h2, got);

    // Random mixed traffic within the preloaded region.
    for (int n = 0; n < 400; n++) begin
      f  = 1'($urandom_range(0, 1));
      pc = BASE + 32'($urandom_range(0, 511));
      a  = BASE + 32'($urandom_range(0, 511));
      wd = $urandom;
      tg = 11'($urandom);
      rd = 1'b0; wr = 4'h0; mt = 1'b0;
      case ($urandom_range(0, 3))
        1: rd = 1'b1;
        2: begin wr = 4'($urandom_range(1, 15)); rd = 1'($urandom_range(0, 1)); end
        3: mt = 1'b1;
        default: ;
      endcase
      mem_i_rd_i = f; mem_i_pc_i = pc;
      mem_d_addr_i = a; mem_d_rd_i = rd; mem_d_wr_i = wr; mem_d_data_wr_i = wd;
      mem_d_req_tag_i = tg; mem_d_flush_i = mt;
      exp64  = m_rd64(pc);
      dexp   = m_rd32(a);
      ack_e  = rd | (wr != 0) | mt;
      dchk_e = rd | (wr != 0);
      m_wr(a, wd, wr);
      @(negedge clk);
      chk("rnd_ivalid", 64'(mem_i_valid_o), 64'(f));
      if (f) chk("rnd_inst", mem_i_inst_o, exp64);
      chk("rnd_ack", 64'(mem_d_ack_o), 64'(ack_e));
      if (ack_e) chk("rnd_tag", 64'(mem_d_resp_tag_o), 64'(tg));
      if (dchk_e) chk("rnd_drd", 64'(mem_d_data_rd_o), 64'(dexp));
      chk("rnd_err", 64'({mem_i_error_o, mem_d_error_o}), 64'd0);
    end
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcm_dual_mem.md
Name: tcm_dual_mem

Overview:
Dual-port tightly-coupled memory serving the core's 64-bit instruction-fetch port and 32-bit data port from a single 64-bit-wide RAM array. It sits directly beside the core with no cache. Both ports are always ready and respond with fixed one-cycle latency. The array has a simulation backdoor for loading program images.

Parameters:
MEM_BYTES, 131072, array size in bytes; power of two; depth = MEM_BYTES/8 64-bit words.
BASE_ADDR, 32'h80000000, window base; used only when TCM_ADDR_CHECK_EN is defined.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
mem_i_rd_i  in  1  fetch request
mem_i_flush_i  in  1  accepted, no effect
mem_i_invalidate_i  in  1  accepted, no effect
mem_i_pc_i  in  32  fetch address (8-byte aligned; bits[2:0] ignored)
mem_i_accept_o  out  1  fetch accepted
mem_i_valid_o  out  1  fetch data valid
mem_i_error_o  out  1  fetch error
mem_i_inst_o  out  64  fetched doubleword
mem_d_addr_i  in  32  data byte address (bits[1:0] ignored)
mem_d_data_wr_i  in  32  write data
mem_d_rd_i  in  1  read request
mem_d_wr_i  in  4  byte write strobes
mem_d_cacheable_i  in  1  ignored
mem_d_req_tag_i  in  11  request tag
mem_d_invalidate_i  in  1  maintenance request, no data effect
mem_d_writeback_i  in  1  maintenance request, no data effect
mem_d_flush_i  in  1  maintenance request, no data effect
mem_d_data_rd_o  out  32  read data
mem_d_accept_o  out  1  request accepted
mem_d_ack_o  out  1  response valid
mem_d_error_o  out  1  response error
mem_d_resp_tag_o  out  11  tag of the acked request

Behaviour:
- Reset values: mem_i_valid_o=0, mem_i_error_o=0, mem_i_inst_o=0, mem_d_ack_o=0, mem_d_error_o=0, mem_d_data_rd_o=0, mem_d_resp_tag_o=0. RAM contents are not cleared. Requests present while rst_i=1 are dropped: no ack/valid afterwards and no write.
- mem_i_accept_o=1 and mem_d_accept_o=1 at all times, including during reset. There is no back-pressure.
- Word index = addr[log2(MEM_BYTES)-1:3]. Upper bits are discarded, so addresses wrap modulo MEM_BYTES.
- Fetch: when mem_i_rd_i is high at edge N, at edge N+1 mem_i_valid_o=1 and mem_i_inst_o=ram[index(pc)]. Otherwise mem_i_valid_o=0. Back-to-back fetches give valid every cycle.
- Data request = mem_d_rd_i | (|mem_d_wr_i) | invalidate | writeback | flush. Each request at edge N gives mem_d_ack_o=1 for exactly one cycle at N+1, with mem_d_resp_tag_o = the captured tag.
- Read: mem_d_data_rd_o = addr[2] ? ram[idx][63:32] : ram[idx][31:0], one-cycle latency.
- Write: byte lane b (0..3) is written when wr_i[b]=1. The target byte is bit offset 32*addr[2]+8*b in ram[idx]. Unselected bytes are unchanged. For a write, mem_d_data_rd_o returns the pre-write word.
- Maintenance-only requests: ack and tag returned, RAM untouched, data_rd is don't-care (drive read of idx).
- Collision: a data write and a fetch to the same word in the same cycle → the fetch returns old data (read-before-write). The write lands, and the next fetch sees the new data.
- Error outputs are 0 unless the optional feature below is compiled in.
- Backdoor: a simulation task write(input [31:0] addr, input [7:0] data) writes one byte at byte offset addr mod MEM_BYTES. The array is reachable hierarchically as u_ram.ram[word], 64 bits wide, little-endian bytes.

Optional Feature:
TCM_ADDR_CHECK_EN:
- Defined: an access is out-of-window when its address is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES).
  - Out-of-window fetch still gives valid at N+1, with mem_i_error_o=1 and inst=0.
  - Out-of-window data access gives ack with mem_d_error_o=1, the write is suppressed, and data_rd=0.
- Undefined: no check, addresses wrap, error outputs are tied to 0.

Test Plan:
- Backdoor write bytes 0x13,0x00,0x00,0x00 at offsets 0..3; fetch pc=0x80000000 → valid at next cycle with inst[31:0]=0x00000013.
- Data write addr 0x80000104, data 0xDEADBEEF, wr=4'b1111, tag=0x5 → ack next cycle, resp_tag=0x5. Then read 0x80000104 → 0xDEADBEEF; read 0x80000100 → previous value unchanged.
- Partial write wr=4'b0010, data 0x0000AB00 onto word 0x11223344 → readback 0x1122AB44.
- Back-to-back reads with tags 1,2,3 on consecutive cycles → three consecutive acks carrying tags 1,2,3 in order.
- Same-cycle data write and fetch to word 0x80018000 → fetch returns old value; a fetch one cycle later returns the new value.
- rst_i asserted with rd_i=1 → no ack/valid on the following cycle, all outputs 0. With TCM_ADDR_CHECK_EN, a read of 0x90000000 → ack with error=1.
